// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;
  localparam int   ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// MULT   | one Booth step per cycle, counter 0..WIDTH-1
// DIV    | one restoring quotient bit per cycle, counter 0..WIDTH-1
// FINISH | done pulse, result already registered; returns to IDLE
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;

  // Shared accumulator: acc_p is Booth P (sign-extended) or the partial remainder,
  // acc_q is the multiplier or the dividend/quotient, acc_qm1 is the Booth q-1 bit.
  logic [WIDTH:0]   acc_p;
  logic [WIDTH-1:0] acc_q;
  logic             acc_qm1;
  logic [WIDTH:0]   m;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             armed;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   p_sum;
  logic [WIDTH:0]   booth_p;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   r_new;
  logic             q_bit;
  logic [WIDTH-1:0] div_q;

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;

    p_sum = acc_p;
    case ({acc_q[0], acc_qm1})
      2'b01:   p_sum = acc_p + m;
      2'b10:   p_sum = acc_p - m;
      default: p_sum = acc_p;
    endcase
    booth_p   = {p_sum[WIDTH], p_sum[WIDTH:1]};
    booth_q   = {p_sum[0], acc_q[WIDTH-1:1]};
    booth_qm1 = acc_q[0];

    r_sh = {acc_p[WIDTH-1:0], acc_q[WIDTH-1]};
    diff = {1'b0, r_sh} - {1'b0, m};
    if (!diff[WIDTH+1]) begin
      r_new = diff[WIDTH:0];
      q_bit = 1'b1;
    end else begin
      r_new = r_sh;
      q_bit = 1'b0;
    end
    div_q = {acc_q[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc_p   <= '0;
      acc_q   <= '0;
      acc_qm1 <= 1'b0;
      m       <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      // The first edge after reset release only arms the unit.
      armed <= 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && armed) begin
            busy    <= 1'b1;
            cnt     <= '0;
            acc_p   <= '0;
            acc_qm1 <= 1'b0;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
            if (op == OP_DIV) begin
              acc_q <= a_mag;
              m     <= {1'b0, b_mag};
              if (b == '0) begin
                div0  <= 1'b1;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                div0  <= 1'b0;
                state <= DIV;
              end
            end else begin
              acc_q <= b;
              m     <= {a[WIDTH-1], a};
              div0  <= 1'b0;
              state <= MULT;
            end
          end
        end

        MULT: begin
          acc_p   <= booth_p;
          acc_q   <= booth_q;
          acc_qm1 <= booth_qm1;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi    <= booth_p[WIDTH-1:0];
            lo    <= booth_q;
            done  <= 1'b1;
            state <= FINISH;
          end
        end

        DIV: begin
          acc_p <= r_new;
          acc_q <= div_q;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            lo    <= neg_q ? -div_q : div_q;
            hi    <= neg_r ? -r_new[WIDTH-1:0] : r_new[WIDTH-1:0];
            done  <= 1'b1;
            state <= FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus busy-start and reset corner sequences.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_div0;
    logic [7:0]  lat;
  } vec_t;

  localparam int NVEC = 16;
  localparam int MAXK = 36;
  vec_t vecs[NVEC];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept happens on the posedge after the negedge drive; k counts cycles N+1, N+2, ...
  task automatic run_vec(input vec_t v, input bit inject, input string name);
    int          first_done;
    int          ndone;
    logic        busy_ok;
    logic        d0_k1;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_d0;
    first_done = 0;
    ndone      = 0;
    busy_ok    = 1'b1;
    d0_k1      = 1'b0;
    r_hi       = '0;
    r_lo       = '0;
    r_d0       = 1'b0;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0; op = OP_DIV;
    for (int k = 1; k <= MAXK; k++) begin
      @(negedge clk);
      if (k == 1) d0_k1 = div0;
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) begin
          first_done = k;
          r_hi = hi; r_lo = lo; r_d0 = div0;
        end
      end
      if (busy !== (k <= int'(v.lat))) busy_ok = 1'b0;
      if (inject) begin
        if (k == 5 || k == 20) begin
          start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({name, " latency"}, first_done, int'(v.lat));
    chk({name, " done_count"}, ndone, 1);
    chk({name, " busy_window"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " div0_at_accept+1"}, {31'b0, d0_k1}, {31'b0, v.exp_div0});
    chk({name, " hi"}, r_hi, v.exp_hi);
    chk({name, " lo"}, r_lo, v.exp_lo);
    chk({name, " div0_at_done"}, {31'b0, r_d0}, {31'b0, v.exp_div0});
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;

    //            op       a             b             exp_hi        exp_lo        d0    lat
    vecs[0]  = '{OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 8'd33};
    vecs[1]  = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 8'd33};
    vecs[2]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 8'd33};
    vecs[3]  = '{OP_MULT, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 8'd33};
    vecs[4]  = '{OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 8'd33};
    vecs[5]  = '{OP_MULT, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 8'd33};
    vecs[6]  = '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 8'd33};
    vecs[7]  = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 8'd33};
    vecs[8]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 8'd33};
    vecs[9]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 8'd33};
    vecs[10] = '{OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, 8'd33};
    vecs[11] = '{OP_DIV,  32'h80000000, 32'h80000000, 32'd0,        32'd1,        1'b0, 8'd33};
    vecs[12] = '{OP_DIV,  32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 8'd33};
    vecs[13] = '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 8'd33};
    // divide by zero keeps the 2/14 left by the previous entry
    vecs[14] = '{OP_DIV,  32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 8'd1};
    vecs[15] = '{OP_MULT, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 8'd33};

    reset = 1'b0; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div0", {31'b0, div0}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // start pulses during a busy divide must be ignored
    v = '{OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 8'd33};
    run_vec(v, 1'b1, "busy_start_ignored");

    // reset in the middle of a multiply
    @(negedge clk);
    op = OP_MULT; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset div0", {31'b0, div0}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    chk("inreset busy", {31'b0, busy}, 32'd0);
    // start offered on the first edge after release is ignored
    reset = 1'b1;
    op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_edge_start_ignored busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("after_release idle", {31'b0, busy | done}, 32'd0);
    v = '{OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 8'd33};
    run_vec(v, 1'b0, "post_reset_mult");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
